frozen_map_stream: RTL

- Sequential, parametrised successor to the combinational frozen-bit insert/recover pair.
- Streams one bit per cycle with valid/ready handshakes and supports a runtime information length k ≤ N.
- Holds a loadable reliability table and runs in one of two modes per frame:
  - INSERT: k data bits in → N-bit u-vector out, frozen positions forced to 0.
  - RECOVER: N decoded bits in → k information bits out.
- Sits between the CRC/source stage and the polar encoder, and between the decoder and the sink.

---
 rtl/frozen_map_stream.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/frozen_map_stream.sv
// Streaming frozen-bit mapper: INSERT (k info bits -> N-bit u-vector) or RECOVER (N bits -> k info bits).
// Optional FROZEN_CHECK_EN adds a sticky frozen_err flag for non-zero frozen inputs seen in RECOVER.
module frozen_map_stream #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tbl_we,
  input  logic [IW-1:0] tbl_addr,
  input  logic [IW-1:0] tbl_data,
  input  logic          start,
  input  logic          mode,
  input  logic [IW:0]   k,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last
`ifdef FROZEN_CHECK_EN
  ,
  output logic          frozen_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_RUN} state_e;

  localparam logic [IW:0]   K_MAX = (IW+1)'(N);
  localparam logic [IW-1:0] P_END = IW'(N - 1);

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [IW:0]   k_q, k_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] last_pos_q, last_pos_d;
  logic          done_q, done_d;

  logic [IW-1:0] tbl_mem [N];
  logic [IW-1:0] tbl_rd;
  logic          is_info;
  logic          p_end;
  logic          adv;

  always_ff @(posedge clk) begin
    if (tbl_we && state_q == S_IDLE) tbl_mem[tbl_addr] <= tbl_data;
  end

  // cnt_q is the table slot during BUILD and the stream position during RUN
  assign tbl_rd  = tbl_mem[cnt_q];
  assign is_info = mask_q[cnt_q];
  assign p_end   = (cnt_q == P_END);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    k_d        = k_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    last_pos_d = last_pos_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_bit    = 1'b0;
    out_last   = 1'b0;
    adv        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          k_d        = (k > K_MAX) ? K_MAX : k;
          mask_d     = '0;
          cnt_d      = '0;
          last_pos_d = '0;
          state_d    = (k == '0) ? S_RUN : S_BUILD;
        end
      end
      S_BUILD: begin
        mask_d[tbl_rd] = 1'b1;
        if (tbl_rd > last_pos_q) last_pos_d = tbl_rd;
        if ({1'b0, cnt_q} == k_q - 1'b1) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (is_info) begin
          out_valid = in_valid;
          out_bit   = in_bit;
          in_ready  = out_ready;
          adv       = in_valid & out_ready;
        end else if (!mode_q) begin
          out_valid = 1'b1;
          adv       = out_ready;
        end else begin
          in_ready = 1'b1;
          adv      = in_valid;
        end
        // with k=0 no mask bit is set, so RECOVER never flags a last bit
        out_last = mode_q ? (is_info && cnt_q == last_pos_q) : p_end;
        if (adv) begin
          cnt_d = cnt_q + 1'b1;
          if (p_end) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      k_q        <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      last_pos_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      last_pos_q <= last_pos_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

`ifdef FROZEN_CHECK_EN
  logic ferr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ferr_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      ferr_q <= 1'b0;
    end else if (state_q == S_RUN && mode_q && !is_info && in_valid && in_bit) begin
      ferr_q <= 1'b1;
    end
  end

  assign frozen_err = ferr_q;
`endif

endmodule
